// File: rtl/rv32i_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds the opcode constants, the immediate-format codes (also decoded by the
// immediate extender), the datapath mux encodings and the control FSM states.
package rv32i_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    // Next-PC source
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ALU   = 2'd2;

    // ALU operand selects
    localparam logic [1:0] A_RS1  = 2'd0;
    localparam logic [1:0] A_PC   = 2'd1;
    localparam logic [1:0] A_ZERO = 2'd2;
    localparam logic [1:0] B_RS2  = 2'd0;
    localparam logic [1:0] B_IMM  = 2'd1;

    // ALU operation class
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_R   = 2'd1;
    localparam logic [1:0] ALU_I   = 2'd2;

    // Register writeback source
    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_LOAD   = 2'd1;
    localparam logic [1:0] WB_PC4    = 2'd2;

    typedef enum logic [3:0] {
        ST_RST,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_WB_ALU,
        ST_MEM_ADDR,
        ST_MEM_RD,
        ST_WB_MEM,
        ST_MEM_WR,
        ST_BRANCH,
        ST_JUMP,
        ST_TRAP
    } state_t;

    // Immediate format implied by the opcode; I is the harmless default for
    // formats that carry no immediate (OP, FENCE).
    function automatic logic [2:0] imm_sel_of(input logic [6:0] opcode);
        logic [2:0] sel;
        case (opcode)
            OPC_STORE:           sel = IMM_S;
            OPC_BRANCH:          sel = IMM_B;
            OPC_LUI, OPC_AUIPC:  sel = IMM_U;
            OPC_JAL:             sel = IMM_J;
            default:             sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv32i_instr_legal.sv
// Combinational RV32I legality check on opcode / funct3 / funct7.
// Ports:
//   opcode  in  7  instr[6:0]
//   funct3  in  3  instr[14:12]
//   funct7  in  7  instr[31:25]
//   legal   out 1  1 = encoding is a supported RV32I instruction
// FENCE_NOP selects whether FENCE is accepted (as a NOP) or rejected.
module rv32i_instr_legal
    import rv32i_pkg::*;
#(
    parameter int FENCE_NOP = 1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       legal
);

    logic f7_zero;
    logic f7_alt;

    assign f7_zero = (funct7 == 7'b0000000);
    assign f7_alt  = (funct7 == 7'b0100000);

    always_comb begin
        legal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL: legal = 1'b1;
            OPC_JALR:   legal = (funct3 == 3'b000);
            OPC_BRANCH: legal = !(funct3 inside {3'b010, 3'b011});
            OPC_LOAD:   legal = !(funct3 inside {3'b011, 3'b110, 3'b111});
            OPC_STORE:  legal = (funct3 < 3'b011);
            // Only SUB and SRA use the alternate funct7.
            OPC_OP:     legal = f7_zero || (f7_alt && (funct3 inside {3'b000, 3'b101}));
            // Shift-immediates reuse funct7 as a qualifier; other funct3 values
            // carry immediate bits there.
            OPC_OP_IMM: begin
                if (funct3 == 3'b001)
                    legal = f7_zero;
                else if (funct3 == 3'b101)
                    legal = f7_zero || f7_alt;
                else
                    legal = 1'b1;
            end
            OPC_FENCE:  legal = (FENCE_NOP != 0);
            default:    legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv32i_multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core.
// Sequences FETCH / DECODE / EXEC / memory / writeback over a shared ALU and
// a shared memory port, flags illegal encodings and counts retirements.
// Ports:
//   clk, reset        clock (rising edge) and synchronous active-high reset
//   instr             IR contents, valid from DECODE onward
//   mem_ready         completes the memory access of the current cycle
//   br_taken          branch comparator result, used in BRANCH
//   ir_write, pc_write, pc_src            IR / PC update controls
//   mem_req, mem_we, mem_addr_src         memory port controls
//   alu_a_sel, alu_b_sel, alu_op          ALU operand / operation selects
//   imm_sel                               immediate format for the extender
//   wb_sel, reg_write                     register writeback controls
//   illegal                               sticky illegal-instruction flag
//   instret                               retired-instruction counter
module rv32i_multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int FENCE_NOP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_src,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic [2:0]       imm_sel,
    output logic [1:0]       wb_sel,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    state_t     state;
    state_t     next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       legal;
    logic       retire;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    // Register and immediate fields belong to the datapath, not to control.
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    rv32i_instr_legal #(
        .FENCE_NOP (FENCE_NOP)
    ) u_legal (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_RST;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            state <= next_state;
            if (next_state == ST_TRAP)
                illegal <= 1'b1;
            if (retire)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        next_state   = state;
        retire       = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS4;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_src = 1'b0;
        alu_a_sel    = A_RS1;
        alu_b_sel    = B_RS2;
        alu_op       = ALU_ADD;
        imm_sel      = IMM_I;
        wb_sel       = WB_ALUOUT;
        reg_write    = 1'b0;

        // Reset gates every strobe combinationally so an abandoned
        // instruction cannot commit anything in the reset cycle itself.
        if (!reset) begin
            case (state)
                ST_RST: next_state = ST_FETCH;

                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        next_state = ST_DECODE;
                    end
                end

                ST_DECODE: begin
                    imm_sel = imm_sel_of(opcode);
                    if (!legal) begin
                        next_state = ST_TRAP;
                    end else begin
                        case (opcode)
                            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: next_state = ST_EXEC;
                            OPC_LOAD, OPC_STORE:                   next_state = ST_MEM_ADDR;
                            OPC_BRANCH:                            next_state = ST_BRANCH;
                            OPC_JAL, OPC_JALR:                     next_state = ST_JUMP;
                            OPC_FENCE: begin
                                pc_write   = 1'b1;
                                pc_src     = PC_PLUS4;
                                retire     = 1'b1;
                                next_state = ST_FETCH;
                            end
                            default:                               next_state = ST_TRAP;
                        endcase
                    end
                end

                ST_EXEC: begin
                    imm_sel = imm_sel_of(opcode);
                    case (opcode)
                        OPC_OP: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_RS2;
                            alu_op    = ALU_R;
                        end
                        OPC_OP_IMM: begin
                            alu_a_sel = A_RS1;
                            alu_b_sel = B_IMM;
                            alu_op    = ALU_I;
                        end
                        OPC_LUI: begin
                            alu_a_sel = A_ZERO;
                            alu_b_sel = B_IMM;
                        end
                        OPC_AUIPC: begin
                            alu_a_sel = A_PC;
                            alu_b_sel = B_IMM;
                        end
                        default: ;
                    endcase
                    next_state = ST_WB_ALU;
                end

                ST_WB_ALU: begin
                    reg_write  = 1'b1;
                    wb_sel     = WB_ALUOUT;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    next_state = ST_FETCH;
                end

                ST_MEM_ADDR: begin
                    imm_sel    = imm_sel_of(opcode);
                    alu_a_sel  = A_RS1;
                    alu_b_sel  = B_IMM;
                    next_state = (opcode == OPC_STORE) ? ST_MEM_WR : ST_MEM_RD;
                end

                ST_MEM_RD: begin
                    mem_req      = 1'b1;
                    mem_addr_src = 1'b1;
                    if (mem_ready)
                        next_state = ST_WB_MEM;
                end

                ST_WB_MEM: begin
                    reg_write  = 1'b1;
                    wb_sel     = WB_LOAD;
                    pc_write   = 1'b1;
                    retire     = 1'b1;
                    next_state = ST_FETCH;
                end

                ST_MEM_WR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_src = 1'b1;
                    if (mem_ready) begin
                        pc_write   = 1'b1;
                        retire     = 1'b1;
                        next_state = ST_FETCH;
                    end
                end

                ST_BRANCH: begin
                    imm_sel    = IMM_B;
                    pc_write   = 1'b1;
                    pc_src     = br_taken ? PC_IMM : PC_PLUS4;
                    retire     = 1'b1;
                    next_state = ST_FETCH;
                end

                ST_JUMP: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_PC4;
                    pc_write  = 1'b1;
                    retire    = 1'b1;
                    if (opcode == OPC_JALR) begin
                        imm_sel   = IMM_I;
                        alu_a_sel = A_RS1;
                        alu_b_sel = B_IMM;
                        pc_src    = PC_ALU;
                    end else begin
                        imm_sel = IMM_J;
                        pc_src  = PC_IMM;
                    end
                    next_state = ST_FETCH;
                end

                // Parked with every request and write deasserted until reset.
                ST_TRAP: next_state = ST_TRAP;

                default: next_state = ST_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_multicycle_ctrl.sv
// Self-checking bench for rv32i_multicycle_ctrl: directed instructions from
// the test plan followed by randomized instructions, memory wait states and
// occasional mid-instruction resets, checked against an instruction-level model.
module tb_rv32i_multicycle_ctrl;

    localparam int FENCE_NOP = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic        ir_write, pc_write, mem_req, mem_we, mem_addr_src, reg_write, illegal;
    logic [1:0]  pc_src, alu_a_sel, alu_b_sel, alu_op, wb_sel;
    logic [2:0]  imm_sel;
    logic [31:0] instret;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_ret = 0;

    rv32i_multicycle_ctrl #(
        .CNT_W     (32),
        .FENCE_NOP (FENCE_NOP)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .instr        (instr),
        .mem_ready    (mem_ready),
        .br_taken     (br_taken),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_src (mem_addr_src),
        .alu_a_sel    (alu_a_sel),
        .alu_b_sel    (alu_b_sel),
        .alu_op       (alu_op),
        .imm_sel      (imm_sel),
        .wb_sel       (wb_sel),
        .reg_write    (reg_write),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got=running exp=finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [18:0] outs();
        return {ir_write, pc_write, pc_src, mem_req, mem_we, mem_addr_src,
                alu_a_sel, alu_b_sel, alu_op, imm_sel, wb_sel, reg_write};
    endfunction

    // Instruction-level expectations taken straight from the ISA class rules.
    typedef struct {
        bit         legal;
        int         base;     // cycles with zero memory wait
        bit         mem;      // has a data access
        bit         store;
        bit         rw;       // writes the register file
        logic [1:0] wb;
        logic [1:0] pcs;
        logic [2:0] imm;      // imm_sel seen in DECODE
        logic [5:0] alu;      // {a, b, op} in the cycle after DECODE
        bit         fence;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic br);
        exp_t e;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        e = '{legal: 1, base: 4, mem: 0, store: 0, rw: 0, wb: 2'd0, pcs: 2'd0,
              imm: 3'd0, alu: 6'd0, fence: 0};
        case (op)
            7'b0110011: begin // OP
                e.legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.rw = 1; e.alu = {2'd0, 2'd0, 2'd1};
            end
            7'b0010011: begin // OP-IMM
                if (f3 == 3'd1) e.legal = (f7 == 7'h00);
                if (f3 == 3'd5) e.legal = (f7 == 7'h00) || (f7 == 7'h20);
                e.rw = 1; e.alu = {2'd0, 2'd1, 2'd2};
            end
            7'b0110111: begin e.rw = 1; e.imm = 3'd3; e.alu = {2'd2, 2'd1, 2'd0}; end // LUI
            7'b0010111: begin e.rw = 1; e.imm = 3'd3; e.alu = {2'd1, 2'd1, 2'd0}; end // AUIPC
            7'b0000011: begin // LOAD
                e.legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
                e.base = 5; e.mem = 1; e.rw = 1; e.wb = 2'd1; e.alu = {2'd0, 2'd1, 2'd0};
            end
            7'b0100011: begin // STORE
                e.legal = (f3 <= 3'd2);
                e.mem = 1; e.store = 1; e.imm = 3'd1; e.alu = {2'd0, 2'd1, 2'd0};
            end
            7'b1100011: begin // BRANCH
                e.legal = !(f3 == 3'd2 || f3 == 3'd3);
                e.base = 3; e.imm = 3'd2; e.pcs = br ? 2'd1 : 2'd0;
            end
            7'b1101111: begin e.base = 3; e.rw = 1; e.wb = 2'd2; e.pcs = 2'd1; e.imm = 3'd4; end // JAL
            7'b1100111: begin // JALR
                e.legal = (f3 == 3'd0);
                e.base = 3; e.rw = 1; e.wb = 2'd2; e.pcs = 2'd2; e.alu = {2'd0, 2'd1, 2'd0};
            end
            7'b0001111: begin e.legal = (FENCE_NOP != 0); e.base = 2; e.fence = 1; end
            default: e.legal = 0;
        endcase
        return e;
    endfunction

    // Assert reset for one cycle and check the recovery: quiet reset cycle,
    // cleared flags in RST, FETCH two cycles after the assertion.
    task automatic reset_seq();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        br_taken = 1'($urandom_range(0, 1));
        #1;
        check_val("rst_cycle_quiet", 32'(outs()), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_val("rst_state_outs", 32'(outs()), 32'h0);
        check_val("rst_illegal", 32'(illegal), 32'h0);
        check_val("rst_instret", instret, 32'h0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("fetch_after_rst", 32'({mem_req, mem_addr_src}), 32'h2);
        @(posedge clk);
        exp_ret = 0;
    endtask

    // Run one instruction from FETCH. The bench acts as memory: each access
    // waits wf (fetch) or wd (data) cycles before mem_ready. abort_at >= 0
    // asserts reset after that many cycles.
    task automatic run_instr(input logic [31:0] ins, input int wf, input int wd,
                             input logic br, input int abort_at);
        exp_t       e = model(ins, br);
        int         cyc = 0, fcnt = 0, dcnt = 0, k = -1, rw = 0, we = 0, dreq = 0;
        logic [1:0] wbs = 2'd0, pcs = 2'd0;
        logic [2:0] isel = 3'd0;
        logic [5:0] alu_obs = 6'd0;
        logic       got_ir;
        bit         done = 0;
        while (!done && cyc < 60) begin
            if (cyc == abort_at) begin
                reset_seq();
                return;
            end
            @(negedge clk);
            instr = (k >= 0) ? ins : $urandom;
            br_taken = br;
            if (mem_req && !mem_addr_src) begin
                mem_ready = (fcnt >= wf); fcnt++;
            end else if (mem_req) begin
                mem_ready = (dcnt >= wd); dcnt++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            got_ir = ir_write;
            if (k == 0) isel = imm_sel;
            if (k == 1) alu_obs = {alu_a_sel, alu_b_sel, alu_op};
            if (reg_write) begin rw++; wbs = wb_sel; end
            if (mem_we) we++;
            if (mem_req && mem_addr_src) dreq++;
            if (pc_write) begin pcs = pc_src; done = 1; end
            if (!e.legal && k >= 1) begin
                check_val("trap_quiet", 32'({illegal, mem_req, pc_write, reg_write, mem_we, ir_write}),
                          32'h20);
                if (k == 10) done = 1;
            end
            @(posedge clk);
            cyc++;
            if (got_ir) k = 0;
            else if (k >= 0) k++;
        end
        if (!done) begin
            check_val("timeout", 32'h0, 32'h1);
            reset_seq();
            return;
        end
        #1;
        if (!e.legal) begin
            check_val("trap_instret", instret, exp_ret);
            reset_seq();
            return;
        end
        exp_ret++;
        check_val("cycles", cyc, e.base + wf + (e.mem ? wd : 0));
        check_val("pc_src", 32'(pcs), 32'(e.pcs));
        check_val("reg_write_cycles", rw, e.rw ? 1 : 0);
        if (e.rw) check_val("wb_sel", 32'(wbs), 32'(e.wb));
        check_val("mem_we_cycles", we, e.store ? wd + 1 : 0);
        check_val("data_req_cycles", dreq, e.mem ? wd + 1 : 0);
        check_val("decode_imm_sel", 32'(isel), 32'(e.imm));
        if (!e.fence) check_val("alu_sel", 32'(alu_obs), 32'(e.alu));
        check_val("instret", instret, exp_ret);
        check_val("illegal_clear", 32'(illegal), 32'h0);
    endtask

    logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                             7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0001111};

    initial begin
        logic [31:0] ins;
        logic [6:0]  f7;
        int          sel;
        reset_seq();

        // Directed test-plan sequence
        run_instr(32'h00500093, 0, 0, 1'b0, -1);   // addi x1,x0,5
        run_instr(32'h0040A103, 0, 3, 1'b0, -1);   // lw, 3 wait cycles
        run_instr(32'h0020A423, 0, 0, 1'b0, -1);   // sw
        run_instr(32'h00000463, 0, 0, 1'b1, -1);   // beq taken
        run_instr(32'h00000463, 0, 0, 1'b0, -1);   // beq not taken
        run_instr(32'h010000EF, 0, 0, 1'b0, -1);   // jal x1,16
        run_instr(32'h0000000F, 1, 0, 1'b0, -1);   // fence
        run_instr(32'h00002063, 0, 0, 1'b0, -1);   // branch funct3 010 -> trap
        run_instr(32'h0040A103, 0, 5, 1'b0, 4);    // reset abandons a waiting load

        // Randomized instructions, waits and aborts
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 11);
            ins = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    f7 = 7'h00;
                2:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            ins[31:25] = f7;
            ins[6:0]   = (sel < 10) ? ops[sel] : 7'($urandom);
            run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
